// File: rtl/dis_frame_wr_ctrl.sv
// Display frame write-back: takes deblocked 4x4 blocks and writes them row by row
// into the planar QCIF frame RAM, pulsing end_of_one_frame after the last block.
module dis_frame_wr_ctrl #(
  parameter int PIC_W_MB = 11,
  parameter int PIC_H_MB = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [1:0]   blk_comp,
  input  logic [5:0]   blk_x,
  input  logic [5:0]   blk_y,
  input  logic [127:0] blk_data,
  output logic         dis_frame_RAM_wr,
  output logic [13:0]  dis_frame_RAM_wr_addr,
  output logic [31:0]  dis_frame_RAM_din,
  output logic         end_of_one_frame,
  output logic         blk_err
);

  localparam int LUMA_PITCH   = PIC_W_MB * 4;
  localparam int CHROMA_PITCH = PIC_W_MB * 2;
  localparam int CB_BASE      = PIC_W_MB * PIC_H_MB * 16 * 16 / 4;
  localparam int CR_BASE      = CB_BASE + CB_BASE / 4;
  localparam int TOTAL_BLKS   = PIC_W_MB * PIC_H_MB * 24;
  localparam int LUMA_ROWS    = PIC_H_MB * 4;
  localparam int CHROMA_ROWS  = PIC_H_MB * 2;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_EOF} state_t;

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [11:0]   cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [13:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic          eof_q, eof_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;

  logic [127:0]  data_q;
  logic [6:0]    pitch_q;
  logic          load;

  logic          legal;
  logic [13:0]   base_in;
  logic [6:0]    pitch_in;
  logic [13:0]   x14, y14;
  logic [1:0]    row_nxt;

  assign x14     = 14'(blk_x);
  assign y14     = 14'(blk_y);
  assign row_nxt = row_q + 2'd1;

  // Block-origin address and range check; all arithmetic is 14 bits wide,
  // which covers the largest legal address (9503) without wrap.
  always_comb begin
    legal    = 1'b0;
    base_in  = '0;
    pitch_in = '0;
    case (blk_comp)
      2'd0: begin
        legal    = (blk_x < 6'(LUMA_PITCH)) && (blk_y < 6'(LUMA_ROWS));
        base_in  = y14 * 14'(4 * LUMA_PITCH) + x14;
        pitch_in = 7'(LUMA_PITCH);
      end
      2'd1: begin
        legal    = (blk_x < 6'(CHROMA_PITCH)) && (blk_y < 6'(CHROMA_ROWS));
        base_in  = 14'(CB_BASE) + y14 * 14'(4 * CHROMA_PITCH) + x14;
        pitch_in = 7'(CHROMA_PITCH);
      end
      2'd2: begin
        legal    = (blk_x < 6'(CHROMA_PITCH)) && (blk_y < 6'(CHROMA_ROWS));
        base_in  = 14'(CR_BASE) + y14 * 14'(4 * CHROMA_PITCH) + x14;
        pitch_in = 7'(CHROMA_PITCH);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    eof_d   = 1'b0;
    err_d   = 1'b0;
    ready_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (blk_valid && ready_q) begin
          if (legal) begin
            load    = 1'b1;
            state_d = S_WR;
            row_d   = 2'd0;
            wr_d    = 1'b1;
            addr_d  = base_in;
            din_d   = blk_data[31:0];
            ready_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (row_q == 2'd3) begin
          if (cnt_q == 12'(TOTAL_BLKS - 1)) begin
            cnt_d   = '0;
            state_d = S_EOF;
            eof_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q + 12'd1;
            state_d = S_IDLE;
            ready_d = 1'b1;
          end
        end else begin
          row_d  = row_nxt;
          wr_d   = 1'b1;
          addr_d = addr_q + 14'(pitch_q);
          din_d  = data_q[{row_nxt, 5'b0} +: 32];
        end
      end
      S_EOF: begin
        // Buffer-swap cycle: no write is ever issued alongside the pulse.
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data_q  <= blk_data;
      pitch_q <= pitch_in;
    end
  end

  assign blk_ready             = ready_q;
  assign dis_frame_RAM_wr      = wr_q;
  assign dis_frame_RAM_wr_addr = addr_q;
  assign dis_frame_RAM_din     = din_q;
  assign end_of_one_frame      = eof_q;
  assign blk_err               = err_q;

endmodule

// File: tb/tb_dis_frame_wr_ctrl.sv
// Directed bench for dis_frame_wr_ctrl: block addressing, handshake timing,
// illegal blocks, frame-end pulse over several frames and mid-block reset.
module tb_dis_frame_wr_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [1:0]   blk_comp;
  logic [5:0]   blk_x;
  logic [5:0]   blk_y;
  logic [127:0] blk_data;
  logic         wr;
  logic [13:0]  addr;
  logic [31:0]  din;
  logic         eof;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int n_eof   = 0;
  int n_err   = 0;
  int n_ovl   = 0;

  always #5 clk = ~clk;

  dis_frame_wr_ctrl dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .blk_valid             (blk_valid),
    .blk_ready             (blk_ready),
    .blk_comp              (blk_comp),
    .blk_x                 (blk_x),
    .blk_y                 (blk_y),
    .blk_data              (blk_data),
    .dis_frame_RAM_wr      (wr),
    .dis_frame_RAM_wr_addr (addr),
    .dis_frame_RAM_din     (din),
    .end_of_one_frame      (eof),
    .blk_err               (err)
  );

  always @(negedge clk) begin
    if (wr) n_wr++;
    if (eof) n_eof++;
    if (err) n_err++;
    if (eof && wr) n_ovl++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Returns one step after the handshake edge, i.e. with row 0 on the outputs.
  task automatic send(input logic [1:0] c, input logic [5:0] x, input logic [5:0] y,
                      input logic [127:0] d, input int gap);
    int b;
    blk_valid = 1'b0;
    repeat (gap) step;
    blk_comp  = c;
    blk_x     = x;
    blk_y     = y;
    blk_data  = d;
    blk_valid = 1'b1;
    b = 0;
    while (!blk_ready && b < 50) begin
      step;
      b++;
    end
    if (!blk_ready) chk("hs_timeout", 32'(blk_ready), 32'd1);
    step;
    blk_valid = 1'b0;
  endtask

  task automatic expect_blk(input int base, input int pitch, input logic [127:0] d,
                            input bit last);
    for (int r = 0; r < 4; r++) begin
      chk("wr", 32'(wr), 32'd1);
      chk("addr", 32'(addr), 32'(base + r * pitch));
      chk("din", din, d[32*r +: 32]);
      chk("rdy_busy", 32'(blk_ready), 32'd0);
      if (r < 3) step;
    end
    step;
    chk("wr_done", 32'(wr), 32'd0);
    if (last) begin
      chk("eof_hi", 32'(eof), 32'd1);
      chk("rdy_eof", 32'(blk_ready), 32'd0);
      step;
      chk("eof_lo", 32'(eof), 32'd0);
      chk("rdy_after_eof", 32'(blk_ready), 32'd1);
    end else begin
      chk("eof_idle", 32'(eof), 32'd0);
      chk("rdy_idle", 32'(blk_ready), 32'd1);
    end
  endtask

  task automatic fill(input int n, input int gapmax);
    for (int i = 0; i < n; i++) begin
      send(2'd0, 6'(i % 44), 6'((i / 44) % 36), {4{32'(i)}},
           (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    end
  endtask

  task automatic illegal(input string tag, input logic [1:0] c, input logic [5:0] x,
                         input logic [5:0] y);
    send(c, x, y, {4{32'hDEAD_BEEF}}, 0);
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_wr"}, 32'(wr), 32'd0);
    chk({tag, "_rdy"}, 32'(blk_ready), 32'd1);
    step;
    chk({tag, "_err_lo"}, 32'(err), 32'd0);
    chk({tag, "_wr2"}, 32'(wr), 32'd0);
  endtask

  initial begin
    logic [127:0] d;
    reset_n   = 1'b0;
    blk_valid = 1'b0;
    blk_comp  = '0;
    blk_x     = '0;
    blk_y     = '0;
    blk_data  = '0;
    repeat (3) step;
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_eof", 32'(eof), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdy", 32'(blk_ready), 32'd0);
    reset_n = 1'b1;
    step;
    chk("rdy_release", 32'(blk_ready), 32'd1);

    // Frame 1: three directed blocks, illegal drops, filler, frame-ending block.
    d = {32'h33323130, 32'h23222120, 32'h13121110, 32'h03020100};
    send(2'd0, 6'd0, 6'd0, d, 0);
    expect_blk(0, 44, d, 1'b0);
    d = {32'hC3C2C1C0, 32'hB3B2B1B0, 32'hA3A2A1A0, 32'h93929190};
    send(2'd2, 6'd21, 6'd17, d, 0);
    expect_blk(9437, 22, d, 1'b0);
    d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    send(2'd1, 6'd3, 6'd2, d, 0);
    expect_blk(6515, 22, d, 1'b0);

    illegal("ill_comp3", 2'd3, 6'd0, 6'd0);
    illegal("ill_lx44", 2'd0, 6'd44, 6'd0);
    illegal("ill_cby18", 2'd1, 6'd0, 6'd18);
    chk("n_err", 32'(n_err), 32'd3);

    fill(2372, 0);
    chk("f1_no_early_eof", 32'(n_eof), 32'd0);
    d = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
    send(2'd2, 6'd21, 6'd17, d, 0);
    expect_blk(9437, 22, d, 1'b1);
    chk("f1_eof_cnt", 32'(n_eof), 32'd1);
    chk("f1_wr_cnt", 32'(n_wr), 32'd9504);

    // Frame 2: random idle gaps between blocks.
    n_wr = 0;
    fill(2375, 8);
    chk("f2_no_early_eof", 32'(n_eof), 32'd1);
    d = {32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100};
    send(2'd0, 6'd43, 6'd35, d, 3);
    expect_blk(6203, 44, d, 1'b1);
    chk("f2_eof_cnt", 32'(n_eof), 32'd2);
    chk("f2_wr_cnt", 32'(n_wr), 32'd9504);

    // Reset during the row-2 write of a partially counted frame.
    fill(10, 0);
    d = {32'h4, 32'h3, 32'h2, 32'h1};
    send(2'd0, 6'd1, 6'd1, d, 0);
    step;
    step;
    chk("row2_addr", 32'(addr), 32'(176 + 1 + 2 * 44));
    reset_n = 1'b0;
    step;
    chk("mid_rst_wr", 32'(wr), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    chk("mid_rst_din", din, 32'd0);
    chk("mid_rst_rdy", 32'(blk_ready), 32'd0);
    reset_n = 1'b1;
    step;
    chk("mid_rst_release_rdy", 32'(blk_ready), 32'd1);
    n_wr = 0;
    fill(2375, 0);
    chk("f3_no_early_eof", 32'(n_eof), 32'd2);
    d = {32'h0, 32'h0, 32'h0, 32'h1234};
    send(2'd1, 6'd0, 6'd0, d, 0);
    expect_blk(6336, 22, d, 1'b1);
    chk("f3_eof_cnt", 32'(n_eof), 32'd3);
    chk("f3_wr_cnt", 32'(n_wr), 32'd9504);
    chk("eof_wr_overlap", 32'(n_ovl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dis_frame_wr_ctrl.md
Name: dis_frame_wr_ctrl

Overview:
- Write-back stage between the deblocking filter and the external frame RAM controller.
- Accepts filtered 4x4 pixel blocks (luma, Cb, Cr) over a valid/ready handshake and writes one 32-bit row per cycle into the display frame RAM.
- Generates the linear 14-bit word address for each row (QCIF planar layout) and counts blocks.
- Pulses end_of_one_frame after the last block of a picture is written. The RAM controller uses this pulse to swap the display and reference buffers.

Parameters:
- PIC_W_MB, 11, picture width in macroblocks (QCIF).
- PIC_H_MB, 9, picture height in macroblocks.
- Derived, fixed by the parameters:
  - LUMA_PITCH = PIC_W_MB*4 words (44)
  - CHROMA_PITCH = PIC_W_MB*2 words (22)
  - CB_BASE = PIC_W_MB*PIC_H_MB*16*16/4 (6336)
  - CR_BASE = CB_BASE + CB_BASE/4 (7920)
  - TOTAL_BLKS = PIC_W_MB*PIC_H_MB*24 (2376)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- blk_valid  in  1  deblocked block available
- blk_ready  out  1  stage can accept a block this cycle
- blk_comp  in  2  0 = luma, 1 = Cb, 2 = Cr, 3 = illegal
- blk_x  in  6  4x4 block column within the plane (luma 0..43, chroma 0..21)
- blk_y  in  6  4x4 block row within the plane (luma 0..35, chroma 0..17)
- blk_data  in  128  four pixel rows; row r occupies [32r+31:32r]; pixel 0 of each row in the LSB byte
- dis_frame_RAM_wr  out  1  write strobe to the RAM controller
- dis_frame_RAM_wr_addr  out  14  word address of the current row
- dis_frame_RAM_din  out  32  row data
- end_of_one_frame  out  1  one-cycle pulse after the final block of a frame is written
- blk_err  out  1  one-cycle pulse when an accepted block is dropped as illegal

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - State = IDLE; row counter and block counter = 0.
  - dis_frame_RAM_wr, end_of_one_frame and blk_err = 0; dis_frame_RAM_wr_addr = 0; dis_frame_RAM_din = 0.
  - blk_ready = 0 while reset_n = 0, and 1 from the first cycle after release.
  - Reset during WR discards the partially written block; rows already written are not rolled back.
- All outputs are registered.
- States: IDLE, WR, EOF.
- IDLE:
  - blk_ready = 1.
  - On blk_valid & blk_ready, register blk_data and compute the base address:
    - luma: (blk_y*4)*LUMA_PITCH + blk_x
    - Cb: CB_BASE + (blk_y*4)*CHROMA_PITCH + blk_x
    - Cr: CR_BASE + (blk_y*4)*CHROMA_PITCH + blk_x
  - The address is computed at full width, then truncated to 14 bits; the maximum legal value is 9503.
- Illegal blocks: blk_comp = 3, or blk_x/blk_y out of range for the component.
  - The block is consumed; blk_err pulses the next cycle.
  - No write occurs, the block counter does not increment, and the state stays IDLE.
- WR:
  - blk_ready = 0.
  - Runs 4 consecutive cycles, row r = 0..3.
  - dis_frame_RAM_wr = 1; addr = base + r*pitch; din = row r of the registered data.
  - After r = 3:
    - If block counter = TOTAL_BLKS-1: counter clears to 0, go to EOF.
    - Otherwise: counter increments, go to IDLE.
- EOF:
  - end_of_one_frame = 1 for exactly one cycle with dis_frame_RAM_wr = 0.
  - blk_ready = 0; return to IDLE.
- Timing (handshake at edge T):
  - Writes occur in cycles T+1..T+4.
  - blk_ready = 1 again at T+5, or at T+6 when the block ends the frame.
  - end_of_one_frame is high at T+5 for a frame-ending block.
  - Maximum throughput: one block per 5 cycles.
- blk_valid without blk_ready: inputs are not sampled; the upstream stage holds them.
- A write never coincides with end_of_one_frame, so buffer swap in the RAM controller is never mid-write.
- Block order within the frame is free; only the count of legal blocks determines the frame end.
- The block counter is 12 bits. A second frame starts counting from 0 with no gap beyond the EOF cycle.

Test Plan:
- Luma block comp=0, x=0, y=0, rows 0x03020100, 0x13121110, 0x23222120, 0x33323130 -> writes at addr 0, 44, 88, 132 with matching din in cycles T+1..T+4; blk_ready low T..T+4 and high at T+5.
- Cr block comp=2, x=21, y=17 -> addrs 9437, 9459, 9481, 9503; Cb block comp=1, x=3, y=2 -> addrs 6515, 6537, 6559, 6581.
- 2376 legal blocks back-to-back with blk_valid held high -> exactly 9504 writes; end_of_one_frame pulses once, 1 cycle after the last write, with wr = 0; the next block starts a new count (verified over 2 frames).
- Illegal inputs: comp=3, or comp=0 with x=44, or comp=1 with y=18 -> blk_err pulse, no dis_frame_RAM_wr, block count unchanged (the frame still needs 2376 legal blocks).
- reset_n driven low during the row-2 write -> next cycle: wr=0, addr=0, counters 0; after release, blk_ready=1 and a new frame needs 2376 full blocks before end_of_one_frame.
- blk_valid held low for random gaps between blocks -> addresses and data unaffected; blk_ready stays 1 in IDLE; no spurious writes.
